// File: rtl/ex_div_unit_pkg.sv
// Shared types for the EX-stage divider: bus widths and FSM state encoding.
package ex_div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned STALL_W   = 6;

    typedef logic [STALL_W-1:0]     stall_bus_t;
    typedef logic [2*DIV_WIDTH-1:0] div_result_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_RUN  = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One combinational radix-2 restoring division iteration.
module div_step
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        // trial MSB set means the subtraction went negative: restore.
        if (!trial[WIDTH]) begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for DIV/DIVU with pipeline stall request.
// Optional DIV_SHORTCUT_EN: skip iteration when |dividend| < |divisor|.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_for_ex
);

`ifdef DIV_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   step_rem, step_quo;

    assign op1_neg = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        if (annul_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        divisor_d = op2_abs;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = op1_abs;
                        // ZERO doubles as the one-cycle direct-result path:
                        // rem/quo are preloaded with the final, unsigned-fixed values.
                        if (opdata2_i == '0) begin
                            state_d = DIV_ZERO;
                            rem_d   = opdata1_i;
                            quo_d   = '1;
                        end else if (SHORTCUT && (op1_abs < op2_abs)) begin
                            state_d = DIV_ZERO;
                            rem_d   = opdata1_i;
                            quo_d   = '0;
                        end else begin
                            state_d = DIV_RUN;
                        end
                    end
                end
                DIV_ZERO: begin
                    result_d = {rem_q, quo_q};
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
                DIV_RUN: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {neg_rem_q ? -step_rem : step_rem,
                                    neg_quo_q ? -step_quo : step_quo};
                        ready_d  = 1'b1;
                        state_d  = DIV_END;
                    end
                end
                DIV_END: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o     = result_q;
    assign ready_o      = ready_q;
    assign stall_for_ex = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: expected results queued at issue, checked on ready_o.
module tb_ex_div_unit;

`ifdef DIV_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_for_ex;

    int          total;
    int          bad;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    int          cyc_g;
    int          last_rdy_cyc;

    ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_i     (signed_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stall_for_ex (stall_for_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] ab;
        aa = (sgn && a[31]) ? -a : a;
        ab = (sgn && b[31]) ? -b : b;
        if (b == 32'd0) return 2;
        if (SHORTCUT && aa < ab) return 2;
        return 33;
    endfunction

    // Result monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && ready_o) begin
            last_rdy_cyc = cyc_g;
            if (exp_q.size() == 0) begin
                chk_eq("spurious_ready", 64'd1, 64'd0);
            end else begin
                chk_eq("result", result_o, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after ready_o.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int  cyc;
        int  nostall;
        bit  got;
        int  lat;
        lat      = exp_lat(sgn, a, b);
        last_exp = model(sgn, a, b);
        exp_q.push_back(last_exp);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        cyc     = 0;
        nostall = 0;
        got     = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                chk_eq("latency", 64'(cyc), 64'(lat));
                chk_eq("stall_in_end", {63'd0, stall_for_ex}, 64'd0);
            end else if (!stall_for_ex) begin
                nostall++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!got) chk_eq("ready_timeout", 64'd0, 64'd1);
        chk_eq("stall_before_ready", 64'(nostall), 64'd0);
        start_i = 1'b0;
    endtask

    initial begin
        int t1;
        total     = 0;
        bad       = 0;
        cyc_g     = 0;
        last_rdy_cyc = 0;
        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;

        #2;
        chk_eq("rst_ready", {63'd0, ready_o}, 64'd0);
        chk_eq("rst_result", result_o, 64'd0);
        chk_eq("rst_stall", {63'd0, stall_for_ex}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
        run_div(1'b0, 32'd3, 32'd9);
        run_div(1'b1, 32'hFFFF_FFFD, 32'd9);

        // Annul in cycle 10, then a fresh DIVU must start from IDLE right away.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        chk_eq("stall_annul", {63'd0, stall_for_ex}, 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        run_div(1'b0, 32'd50, 32'd7);

        run_div(1'b0, 32'd9, 32'd3);
        t1 = last_rdy_cyc;
        run_div(1'b0, 32'd8, 32'd4);
        chk_eq("b2b_gap", 64'(last_rdy_cyc - t1), 64'd34);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            run_div(1'(i % 2), a, b);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("result_hold", result_o, last_exp);

        // Reset mid-operation: the operation is discarded, outputs clear.
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        chk_eq("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk_eq("midrst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);

        chk_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
